guest_card_writer: RTL and testbench
====================================

# guest_card_writer

Front-desk card issuer that drives the card-side interface of `electronic_card_lock`, the other end of that interface. On a `start` request it:
- presents a 16-bit entry code and a 2-bit card type;
- emulates a card insertion and removal with active-low key strobes;
- waits for the lock's `card_read` acknowledge;
- samples the lock's `trip_lock_for_guest` verdict.

It is used on the front-desk side of the card-lock design and as a reusable stimulus engine for card-lock labs.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4 — cycles code/type are stable before the insert strobe (≥1).
- `PULSE_CYCLES`, 2 — width of each active-low key strobe (≥1).
- `HOLD_CYCLES`, 8 — cycles the card stays inserted after `card_read` is seen (≥1).
- `TIMEOUT_CYCLES`, 255 — maximum wait for `card_read` (1..255).

Ports:
- `clk` in 1 — single clock; all state changes on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `start` in 1 — issue request; sampled only in IDLE.
- `code_in` in 16 — entry code, latched on an accepted `start`.
- `type_in` in 2 — card type, latched on an accepted `start`.
- `entry_code_on_card` out 16 — code presented to the lock.
- `card_type` out 2 — type presented to the lock.
- `key_1` out 1 — active-low insert strobe.
- `key_0` out 1 — active-low remove strobe.
- `card_read` in 1 — lock acknowledge; level, sampled each cycle in WAIT_READ.
- `trip_lock_for_guest` in 1 — lock verdict; sampled in SAMPLE.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse in DONE.
- `result_trip` out 1 — sampled verdict; held until the next accepted `start`.
- `result_timeout` out 1 — last transaction timed out; held until the next accepted `start`.
- `cards_issued` out 8 — count of non-timed-out transactions; saturates at 255.

## Operation
- Reset values:
  - `key_0`=`key_1`=1.
  - `entry_code_on_card`=0, `card_type`=0.
  - `busy`=`done`=`result_trip`=`result_timeout`=0, `cards_issued`=0.
  - State IDLE.
- Reset dominates every other input in any state, including mid-transaction. Keys are released on the same edge.
- FSM states:
  - IDLE: code/type outputs driven 0. `start`=1 latches `code_in`/`type_in`, clears both result flags, goes to LOAD.
  - LOAD: latched code/type driven. Stays SETTLE_CYCLES cycles, then INSERT.
  - INSERT: `key_1`=0 for PULSE_CYCLES cycles, then WAIT_READ.
  - WAIT_READ: `card_read`=1 goes to HOLD. After TIMEOUT_CYCLES cycles without it, sets `result_timeout`=1 and goes to REMOVE, skipping HOLD.
  - HOLD: stays HOLD_CYCLES cycles, then REMOVE.
  - REMOVE: `key_0`=0 for PULSE_CYCLES cycles, then SAMPLE.
  - SAMPLE: 1 cycle. `result_trip` ← `trip_lock_for_guest`, forced 0 if `result_timeout`. Then DONE.
  - DONE: 1 cycle, `done`=1. `cards_issued` increments unless timed out (no wrap). Then IDLE.
- Code/type are driven unchanged from LOAD through DONE.
- `key_0` and `key_1` are never both low.
- `start` outside IDLE, including the DONE cycle, is ignored.
- A `card_read` already high on WAIT_READ entry is accepted in that first cycle.
- A `card_read` deassert after acceptance is ignored.
- All cycle counters reset on every state entry.

## Timing
- Every output is registered; there are no combinational paths from input to output.
- With `start` accepted at edge k and defaults, all cycle numbers counted after k:

| Phase | Cycles after k |
|---|---|
| LOAD, `busy`=1, code driven | 1–4 |
| INSERT, `key_1` low | 5–6 |
| WAIT_READ, first cycle | 7 |

- Immediate `card_read`:

| Phase | Cycles after k |
|---|---|
| HOLD | 8–15 |
| REMOVE, `key_0` low | 16–17 |
| SAMPLE | 18 |
| DONE | 19 |

  - `busy` is 0 and the next `start` can be accepted from cycle 20.
- Each cycle of `card_read` delay adds one cycle.
- Timeout:

| Phase | Cycles after k |
|---|---|
| WAIT_READ | 7 to 6+TIMEOUT_CYCLES |
| REMOVE | next 2 |
| SAMPLE | next 1 |
| DONE | next 1 |

- `result_*` update on the SAMPLE→DONE edge, so they are valid while `done`=1.

## Test plan
- Reset, then `start` with `code_in`=16'hBEEF, `type_in`=2'b01, `card_read` tied 1, `trip_lock_for_guest`=1 → `key_1` low at cycles 5–6, `key_0` low at 16–17, `done` at 19, `result_trip`=1, `cards_issued`=1.
- `card_read` held 0, TIMEOUT_CYCLES=255 → WAIT_READ lasts 255 cycles. Expect `key_0` strobe, `result_timeout`=1, `result_trip`=0, `cards_issued` unchanged.
- `card_read` rises 10 cycles into WAIT_READ → `done` at cycle 29.
- Set `cards_issued` to 255 via 255 back-to-back transactions, then one more transaction → `cards_issued` stays at 255.
- `reset` asserted during HOLD → next cycle IDLE, keys high, outputs 0, `cards_issued`=0, no `done`.
- `start` held high continuously → transactions back-to-back. `start` during DONE is ignored; acceptance occurs at the first IDLE cycle.

Source files
------------

// File: rtl/guest_card_writer_if.sv
// guest_card_writer_if: card-side and front-desk signals of the guest card writer
interface guest_card_writer_if;
  logic        start;
  logic [15:0] code_in;
  logic [1:0]  type_in;
  logic [15:0] entry_code_on_card;
  logic [1:0]  card_type;
  logic        key_1;
  logic        key_0;
  logic        card_read;
  logic        trip_lock_for_guest;
  logic        busy;
  logic        done;
  logic        result_trip;
  logic        result_timeout;
  logic [7:0]  cards_issued;
  modport master (
    output start, code_in, type_in, card_read, trip_lock_for_guest,
    input  entry_code_on_card, card_type, key_1, key_0, busy, done,
           result_trip, result_timeout, cards_issued
  );
  modport slave (
    input  start, code_in, type_in, card_read, trip_lock_for_guest,
    output entry_code_on_card, card_type, key_1, key_0, busy, done,
           result_trip, result_timeout, cards_issued
  );
endinterface

// File: rtl/guest_card_writer.sv
// guest_card_writer: front-desk card issuer driving the card side of electronic_card_lock
module guest_card_writer #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int PULSE_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  guest_card_writer_if.slave card_if
);
  typedef enum logic [2:0] {IDLE, LOAD, INSERT, WAIT_READ, HOLD, REMOVE, SAMPLE, DONE} state_e;
  localparam logic [15:0] SETTLE_L  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] PULSE_L   = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] HOLD_L    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYCLES - 1);
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] code_q;
  logic [1:0]  type_q;
  logic        key_1_q, key_0_q, busy_q, done_q;
  logic        trip_q, timeout_q, timed_out_q;
  logic [7:0]  issued_q;
  logic        accept, expire;
  assign accept = state_q == IDLE && card_if.start;
  assign expire = state_q == WAIT_READ && !card_if.card_read && cnt_q == TIMEOUT_L;
  assign card_if.entry_code_on_card = code_q;
  assign card_if.card_type          = type_q;
  assign card_if.key_1              = key_1_q;
  assign card_if.key_0              = key_0_q;
  assign card_if.busy               = busy_q;
  assign card_if.done               = done_q;
  assign card_if.result_trip        = trip_q;
  assign card_if.result_timeout     = timeout_q;
  assign card_if.cards_issued       = issued_q;
  // next phase of the issue sequence; the dwell counter restarts on every phase change
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = card_if.start ? LOAD : IDLE;
      LOAD:      state_d = cnt_q == SETTLE_L ? INSERT : LOAD;
      INSERT:    state_d = cnt_q == PULSE_L ? WAIT_READ : INSERT;
      WAIT_READ: state_d = card_if.card_read ? HOLD : (expire ? REMOVE : WAIT_READ);
      HOLD:      state_d = cnt_q == HOLD_L ? REMOVE : HOLD;
      REMOVE:    state_d = cnt_q == PULSE_L ? SAMPLE : REMOVE;
      SAMPLE:    state_d = DONE;
      default:   state_d = IDLE;
    endcase
    cnt_d = (state_d == state_q && state_q != IDLE) ? cnt_q + 16'd1 : '0;
  end
  // sequencer with every output registered from the upcoming phase
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      code_q      <= '0;
      type_q      <= '0;
      key_1_q     <= 1'b1;
      key_0_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      trip_q      <= 1'b0;
      timeout_q   <= 1'b0;
      timed_out_q <= 1'b0;
      issued_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      code_q      <= accept ? card_if.code_in : (state_d == IDLE ? '0 : code_q);
      type_q      <= accept ? card_if.type_in : (state_d == IDLE ? '0 : type_q);
      key_1_q     <= state_d != INSERT;
      key_0_q     <= state_d != REMOVE;
      busy_q      <= state_d != IDLE;
      done_q      <= state_d == DONE;
      timed_out_q <= accept ? 1'b0 : (expire | timed_out_q);
      if (accept) begin
        trip_q    <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (state_q == SAMPLE) begin
        trip_q    <= card_if.trip_lock_for_guest & ~timed_out_q;
        timeout_q <= timed_out_q;
        issued_q  <= (timed_out_q || issued_q == 8'hFF) ? issued_q : issued_q + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_guest_card_writer.sv
// tb_guest_card_writer: timeline model plus directed transactions for guest_card_writer
module tb_guest_card_writer;
  localparam int S = 4, P = 2, H = 8, T = 255, W0 = S + P + 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  guest_card_writer_if card_if();
  guest_card_writer dut (.clk(clk), .reset(reset), .card_if(card_if.slave));
  int checks = 0, passed = 0;
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, a, e);
  endtask
  bit          m_act = 0, m_to = 0, m_tof = 0, m_trip = 0;
  int          m_t = 0, m_r0 = 0, m_cnt = 0;
  logic [15:0] m_code = '0;
  logic [1:0]  m_type = '0;
  initial forever begin
    logic [31:0] a, e;
    bit k1, k0, dn;
    @(posedge clk);
    #1;
    if (reset) begin
      m_act = 0; m_cnt = 0; m_trip = 0; m_tof = 0;
    end else if (!m_act) begin
      if (card_if.start) begin
        m_act = 1; m_t = 0; m_r0 = 0; m_to = 0; m_trip = 0; m_tof = 0;
        m_code = card_if.code_in; m_type = card_if.type_in;
      end
    end else begin
      if (m_r0 == 0 && m_t >= W0) begin
        if (card_if.card_read) m_r0 = m_t + 1 + H;
        else if (m_t == W0 + T - 1) begin m_r0 = m_t + 1; m_to = 1; end
      end
      if (m_r0 != 0 && m_t == m_r0 + P) begin
        m_trip = m_to ? 1'b0 : card_if.trip_lock_for_guest;
        m_tof = m_to;
        if (!m_to && m_cnt < 255) m_cnt++;
      end
      if (m_r0 != 0 && m_t == m_r0 + P + 1) m_act = 0;
    end
    if (m_act) m_t++;
    k1 = !(m_act && m_t >= S + 1 && m_t <= S + P);
    k0 = !(m_act && m_r0 != 0 && m_t >= m_r0 && m_t < m_r0 + P);
    dn = m_act && m_r0 != 0 && m_t == m_r0 + P + 1;
    e = {m_act ? m_code : 16'h0, m_act ? m_type : 2'b0, k1, k0, m_act, dn, m_trip, m_tof, 8'(m_cnt)};
    a = {card_if.entry_code_on_card, card_if.card_type, card_if.key_1, card_if.key_0, card_if.busy,
         card_if.done, card_if.result_trip, card_if.result_timeout, card_if.cards_issued};
    chk("outputs", a, e);
  end
  task automatic txn(input logic [15:0] c, input logic [1:0] ty, input logic tr, input int d,
                     output int done_at, output int k1_at, output int k0_at, output logic [15:0] code1,
                     output logic r_trip, output logic r_to, output logic [7:0] r_cnt);
    done_at = -1; k1_at = -1; k0_at = -1; code1 = '0; r_trip = 1'bx; r_to = 1'bx; r_cnt = 'x;
    card_if.code_in = c; card_if.type_in = ty; card_if.trip_lock_for_guest = tr;
    card_if.card_read = d == 0; card_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    card_if.start = 1'b0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      if (cyc == 1) code1 = card_if.entry_code_on_card;
      if (!card_if.key_1 && k1_at < 0) k1_at = cyc;
      if (!card_if.key_0 && k0_at < 0) k0_at = cyc;
      if (card_if.done) begin
        done_at = cyc; r_trip = card_if.result_trip; r_to = card_if.result_timeout; r_cnt = card_if.cards_issued;
        break;
      end
      card_if.card_read = d == 0 || (d > 0 && cyc >= W0 + d);
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  initial begin
    int da, k1a, k0a, ndone, last, bad, idle_low;
    logic [15:0] c1;
    logic rt, ro;
    logic [7:0] rc, c255;
    card_if.start = 0; card_if.code_in = '0; card_if.type_in = '0;
    card_if.card_read = 0; card_if.trip_lock_for_guest = 0;
    repeat (3) @(negedge clk);
    chk("reset_key_1", card_if.key_1, 1);
    chk("reset_key_0", card_if.key_0, 1);
    chk("reset_busy", card_if.busy, 0);
    chk("reset_cards", card_if.cards_issued, 0);
    reset = 0;
    @(negedge clk);
    txn(16'hBEEF, 2'b01, 1'b1, 0, da, k1a, k0a, c1, rt, ro, rc);
    chk("t1_done_cycle", da, 19);
    chk("t1_key_1_cycle", k1a, 5);
    chk("t1_key_0_cycle", k0a, 16);
    chk("t1_code", c1, 16'hBEEF);
    chk("t1_trip", rt, 1);
    chk("t1_timeout", ro, 0);
    chk("t1_cards", rc, 1);
    chk("t1_idle_busy", card_if.busy, 0);
    txn(16'h1234, 2'b10, 1'b1, -1, da, k1a, k0a, c1, rt, ro, rc);
    chk("to_done_cycle", da, 265);
    chk("to_key_0_cycle", k0a, 262);
    chk("to_trip", rt, 0);
    chk("to_timeout", ro, 1);
    chk("to_cards", rc, 1);
    txn(16'hA5A5, 2'b11, 1'b1, 10, da, k1a, k0a, c1, rt, ro, rc);
    chk("dly_done_cycle", da, 29);
    chk("dly_key_0_cycle", k0a, 26);
    chk("dly_trip", rt, 1);
    chk("dly_timeout", ro, 0);
    chk("dly_cards", rc, 2);
    card_if.code_in = 16'h0F0F; card_if.card_read = 1; card_if.start = 1;
    @(posedge clk);
    @(negedge clk);
    card_if.start = 0;
    repeat (9) @(negedge clk);
    chk("hold_busy", card_if.busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_busy", card_if.busy, 0);
    chk("rst_keys", {card_if.key_1, card_if.key_0}, 2'b11);
    chk("rst_code", card_if.entry_code_on_card, 0);
    chk("rst_cards", card_if.cards_issued, 0);
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      if (card_if.done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    card_if.card_read = 1; card_if.trip_lock_for_guest = 0; card_if.start = 1;
    ndone = 0; last = -1; bad = 0; idle_low = 0; c255 = '0;
    for (int cyc = 0; cyc < 6000 && ndone < 256; cyc++) begin
      @(negedge clk);
      card_if.code_in = 16'($urandom);
      card_if.type_in = 2'($urandom);
      if (ndone > 0 && !card_if.busy) idle_low++;
      if (card_if.done) begin
        if (last >= 0 && cyc - last != 20) bad++;
        last = cyc;
        ndone++;
        if (ndone == 255) c255 = card_if.cards_issued;
      end
    end
    card_if.start = 0;
    chk("b2b_count", ndone, 256);
    chk("b2b_spacing_errors", bad, 0);
    chk("b2b_idle_cycles", idle_low, 255);
    chk("sat_cards_255th", c255, 255);
    chk("sat_cards_final", card_if.cards_issued, 255);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
